// File: rtl/lamp_ramp_controller.sv
// Lamp level sequencer: accepts a target level over valid/ready and ramps the
// lit-lamp count toward it one step every STEP_CYCLES clocks, with emergency off.
module lamp_ramp_controller #(
  parameter int STEP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [3:0] req_level,
  output logic       req_ready,
  input  logic       emergency_off,
  output logic [3:0] active_lights,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RAMP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [3:0]       r_level;
  logic [3:0]       r_target;
  logic             r_up;
  logic [CNT_W-1:0] r_cnt;

  logic       w_xfer;
  logic [3:0] w_stepped;

  assign req_ready     = (r_state == S_IDLE) & ~emergency_off;
  assign w_xfer        = req_valid & req_ready;
  // Direction is latched at acceptance, so the step can never wrap past 0 or 15.
  assign w_stepped     = r_up ? (r_level + 4'd1) : (r_level - 4'd1);
  assign active_lights = r_level;
  assign busy          = (r_state == S_RAMP);
  assign done          = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_level  <= 4'd0;
      r_target <= 4'd0;
      r_up     <= 1'b0;
      r_cnt    <= '0;
    end else if (emergency_off) begin
      r_state  <= S_IDLE;
      r_level  <= 4'd0;
      r_target <= 4'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            if (req_level == r_level) begin
              r_state <= S_DONE;
            end else begin
              r_target <= req_level;
              r_up     <= (req_level > r_level);
              r_cnt    <= CNT_RELOAD;
              r_state  <= S_RAMP;
            end
          end
        end
        S_RAMP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_level <= w_stepped;
            r_cnt   <= CNT_RELOAD;
            if (w_stepped == r_target) r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lamp_ramp_controller.sv
// Randomized bench for lamp_ramp_controller: two instances (4-cycle and unit rate)
// checked every cycle against a timestamp-based reference of the ramp.
module tb_lamp_ramp_controller;

  localparam int NI = 2;
  localparam int SC [NI] = '{4, 1};
  localparam int NQ = 10;
  localparam int DQ [NQ] = '{5, 2, 2, 15, 0, 3, 15, 1, 7, 0};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       emg;
  logic       vld [NI];
  logic [3:0] lvl [NI];
  logic       rdy [NI];
  logic [3:0] al  [NI];
  logic       bz  [NI];
  logic       dn  [NI];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lamp_ramp_controller #(.STEP_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[0]), .req_level(lvl[0]),
    .req_ready(rdy[0]), .emergency_off(emg), .active_lights(al[0]),
    .busy(bz[0]), .done(dn[0])
  );

  lamp_ramp_controller #(.STEP_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[1]), .req_level(lvl[1]),
    .req_ready(rdy[1]), .emergency_off(emg), .active_lights(al[1]),
    .busy(bz[1]), .done(dn[1])
  );

  // Reference: a ramp is described by its acceptance edge, start level and
  // target; every output after edge t follows from those with plain arithmetic.
  int e = -1;
  bit sess [NI];
  int k [NI], l0 [NI], tg [NI], d [NI], base [NI];
  bit xfer [NI];
  int qi [NI];
  bit emg_done = 1'b0;

  function automatic int m_level(int i, int t);
    int steps;
    if (!sess[i]) return base[i];
    steps = (t - k[i]) / SC[i];
    if (steps > d[i]) steps = d[i];
    return (tg[i] >= l0[i]) ? l0[i] + steps : l0[i] - steps;
  endfunction

  function automatic bit m_busy(int i, int t);
    return sess[i] && d[i] > 0 && t >= k[i] && t < k[i] + d[i] * SC[i];
  endfunction

  function automatic bit m_done(int i, int t);
    return sess[i] && t == k[i] + d[i] * SC[i];
  endfunction

  function automatic bit m_idle(int i, int t);
    return !sess[i] || t > k[i] + d[i] * SC[i];
  endfunction

  task automatic chk_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, e, obs, exp);
    end
  endtask

  task automatic model_edge();
    int cur;
    bit idle_prev;
    e++;
    for (int i = 0; i < NI; i++) begin
      idle_prev = m_idle(i, e - 1);
      cur       = m_level(i, e - 1);
      xfer[i]   = 1'b0;
      if (!rst_n || emg) begin
        sess[i] = 1'b0;
        base[i] = 0;
      end else if (idle_prev && vld[i]) begin
        xfer[i] = 1'b1;
        sess[i] = 1'b1;
        k[i]    = e;
        l0[i]   = cur;
        tg[i]   = int'(lvl[i]);
        d[i]    = (tg[i] > cur) ? tg[i] - cur : cur - tg[i];
      end
    end
  endtask

  task automatic drive_inputs(input int cyc);
    if (cyc < 2) begin
      rst_n = 1'b0;
    end else if (cyc < 700) begin
      rst_n = (cyc != 420);
      emg   = 1'b0;
      if (!emg_done && sess[0] && tg[0] == 15 && m_level(0, e) == 9) begin
        emg      = 1'b1;
        emg_done = 1'b1;
      end
    end else begin
      rst_n = ($urandom_range(0, 199) != 0);
      emg   = ($urandom_range(0, 79) == 0);
    end
    for (int i = 0; i < NI; i++) begin
      if (cyc == 2 || xfer[i]) begin
        if (qi[i] < NQ) begin
          vld[i] = 1'b1;
          lvl[i] = 4'(DQ[qi[i]]);
          qi[i]++;
        end else begin
          vld[i] = 1'b0;
        end
      end else if (cyc >= 2 && qi[i] >= NQ && !vld[i] && $urandom_range(0, 3) == 0) begin
        vld[i] = 1'b1;
        lvl[i] = 4'($urandom_range(0, 15));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    emg   = 1'b0;
    for (int i = 0; i < NI; i++) begin
      vld[i]  = 1'b1;
      lvl[i]  = 4'd7;
      sess[i] = 1'b0;
      base[i] = 0;
      qi[i]   = 0;
      k[i] = 0; l0[i] = 0; tg[i] = 0; d[i] = 0;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      model_edge();
      #1;
      for (int i = 0; i < NI; i++) begin
        chk_eq($sformatf("lights[S=%0d]", SC[i]), 8'(al[i]), 8'(m_level(i, e)));
        chk_eq($sformatf("busy[S=%0d]", SC[i]), 8'(bz[i]), 8'(m_busy(i, e)));
        chk_eq($sformatf("done[S=%0d]", SC[i]), 8'(dn[i]), 8'(m_done(i, e)));
      end
      drive_inputs(cyc);
      #1;
      for (int i = 0; i < NI; i++)
        chk_eq($sformatf("ready[S=%0d]", SC[i]), 8'(rdy[i]), 8'(m_idle(i, e) && !emg));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
